// File: rtl/sigmadelta_dac.sv
// Audio output stage: zero-order-hold PCM sample, shift volume, offset-binary conversion,
// soft-start/mute level slewing and a first-order error-feedback sigma-delta quantizer.
module sigmadelta_dac #(
  parameter int unsigned C_pcm_bits   = 12,
  parameter int unsigned C_dac_bits   = 4,
  parameter int unsigned C_ramp_shift = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [C_pcm_bits-1:0] pcm,
  input  logic                  pcm_valid,
  input  logic [2:0]            volume,
  input  logic                  mute,
  output logic [C_dac_bits-1:0] dac,
  output logic                  active
);

  localparam int unsigned ErrBits = C_pcm_bits - C_dac_bits;
  localparam logic [C_pcm_bits-1:0]   Mid     = {1'b1, {(C_pcm_bits-1){1'b0}}};
  localparam logic [C_pcm_bits-1:0]   LvlOne  = {{(C_pcm_bits-1){1'b0}}, 1'b1};
  localparam logic [C_ramp_shift-1:0] RampOne = {{(C_ramp_shift-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StRamp, StRun, StMute} state_e;

  state_e                        state_q, state_d;
  logic signed [C_pcm_bits-1:0]  sample_q;
  logic signed [C_pcm_bits-1:0]  s_att;
  logic [C_pcm_bits-1:0]         s_u;
  logic [C_pcm_bits-1:0]         lvl_q, lvl_d;
  logic [ErrBits-1:0]            err_q;
  logic [C_pcm_bits:0]           sum;
  logic [C_dac_bits-1:0]         dac_d;
  logic [C_ramp_shift-1:0]       ramp_cnt_q;
  logic                          tick;

  // Offset-binary: adding half scale to a two's-complement value is an MSB flip.
  assign s_att = sample_q >>> volume;
  assign s_u   = {~s_att[C_pcm_bits-1], s_att[C_pcm_bits-2:0]};
  assign tick  = &ramp_cnt_q;

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    unique case (state_q)
      StRamp: begin
        if (tick) begin
          lvl_d = lvl_q + LvlOne;
          if (lvl_d == Mid) begin
            state_d = mute ? StMute : StRun;
          end
        end
      end
      StRun: begin
        if (mute) begin
          state_d = StMute;
        end else begin
          lvl_d = s_u;
        end
      end
      StMute: begin
        if (tick) begin
          if (lvl_q < Mid) begin
            lvl_d = lvl_q + LvlOne;
          end else if (lvl_q > Mid) begin
            lvl_d = lvl_q - LvlOne;
          end
        end
        if (!mute) begin
          state_d = StRun;
        end
      end
      default: state_d = StRamp;
    endcase
  end

  // Carry out of the 13-bit sum only happens for levels near full scale; clamp there.
  assign sum   = {1'b0, lvl_q} + {{(C_dac_bits + 1){1'b0}}, err_q};
  assign dac_d = sum[C_pcm_bits] ? {C_dac_bits{1'b1}} : sum[C_pcm_bits-1 -: C_dac_bits];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StRamp;
      sample_q   <= '0;
      lvl_q      <= '0;
      err_q      <= '0;
      ramp_cnt_q <= '0;
      dac        <= '0;
      active     <= 1'b0;
    end else begin
      state_q    <= state_d;
      lvl_q      <= lvl_d;
      err_q      <= sum[ErrBits-1:0];
      ramp_cnt_q <= ramp_cnt_q + RampOne;
      dac        <= dac_d;
      active     <= (state_d == StRun);
      if (pcm_valid) begin
        sample_q <= pcm;
      end
    end
  end

endmodule

// File: tb/tb_sigmadelta_dac.sv
// Self-checking bench for sigmadelta_dac: cycle-level integer model compared every clock,
// plus directed literal expectations for ramp, tones, volume, mute and reset.
module tb_sigmadelta_dac;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] pcm = '0;
  logic        pcm_valid = 1'b0;
  logic [2:0]  volume = '0;
  logic        mute = 1'b0;
  logic [3:0]  dac;
  logic        active;

  int errors = 0;
  int checks = 0;

  sigmadelta_dac dut (
    .clk      (clk),
    .reset    (reset),
    .pcm      (pcm),
    .pcm_valid(pcm_valid),
    .volume   (volume),
    .mute     (mute),
    .dac      (dac),
    .active   (active)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: modes 0=ramp, 1=run, 2=mute; tick every 16th clock since reset.
  int m_sample, m_lvl, m_err, m_mode, m_cyc, m_dac;
  int m_active;
  int t_sum, t_su, t_lvl, t_mode;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_sample = 0; m_lvl = 0; m_err = 0; m_mode = 0; m_cyc = 0; m_dac = 0; m_active = 0;
    end else begin
      t_su   = (m_sample >>> volume) + 2048;
      t_sum  = m_lvl + m_err;
      t_lvl  = m_lvl;
      t_mode = m_mode;
      if (m_mode == 0) begin
        if (m_cyc % 16 == 15) begin
          t_lvl = m_lvl + 1;
          if (t_lvl == 2048) t_mode = mute ? 2 : 1;
        end
      end else if (m_mode == 1) begin
        if (mute) t_mode = 2;
        else t_lvl = t_su;
      end else begin
        if (m_cyc % 16 == 15) begin
          if (m_lvl < 2048) t_lvl = m_lvl + 1;
          else if (m_lvl > 2048) t_lvl = m_lvl - 1;
        end
        if (!mute) t_mode = 1;
      end
      m_dac    = (t_sum >= 4096) ? 15 : t_sum / 256;
      m_err    = t_sum % 256;
      m_lvl    = t_lvl;
      m_mode   = t_mode;
      m_active = (t_mode == 1) ? 1 : 0;
      if (pcm_valid) m_sample = $signed(pcm);
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    check("model_dac", int'(dac), m_dac);
    check("model_active", int'(active), m_active);
    check("model_lvl", int'(dut.lvl_q), m_lvl);
    check("model_err", int'(dut.err_q), m_err);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [11:0] v);
    pcm = v;
    pcm_valid = 1'b1;
    cyc(1);
    pcm_valid = 1'b0;
  endtask

  task automatic steady(input string name, input int exp_dac);
    for (int i = 0; i < 8; i++) begin
      check(name, int'(dac), exp_dac);
      cyc(1);
    end
  endtask

  initial begin
    int n;
    int nines;
    cyc(2);
    check("reset_dac", int'(dac), 0);
    check("reset_active", int'(active), 0);
    reset = 1'b0;
    cyc(3);
    check("early_dac", int'(dac), 0);
    check("early_active", int'(active), 0);
    check("early_lvl", int'(dut.lvl_q), 0);
    cyc(13);
    check("first_tick_lvl", int'(dut.lvl_q), 1);
    n = 16;
    while (!active && n < 40000) begin
      cyc(1);
      n++;
    end
    check("ramp_len", n, 32768);
    check("ramp_end_lvl", int'(dut.lvl_q), 2048);
    cyc(4);
    steady("idle_dac8", 8);

    // Small tone: level 2112 gives a 1-in-4 dither pattern.
    send(12'd64);
    check("lat_e_lvl", int'(dut.lvl_q), 2048);
    cyc(1);
    check("lat_e1_lvl", int'(dut.lvl_q), 2112);
    cyc(20);
    nines = 0;
    for (int i = 0; i < 8; i++) begin
      if (dac == 4'd9) nines++;
      else check("tone64_dac8", int'(dac), 8);
      cyc(1);
    end
    check("tone64_nines", nines, 2);

    send(12'd2047);
    cyc(4);
    steady("full_pos", 15);
    send(12'h800);
    cyc(4);
    steady("full_neg", 0);
    volume = 3'd2;
    send(12'hC00);
    cyc(4);
    check("vol2_lvl", int'(dut.lvl_q), 1792);
    steady("vol2_dac", 7);

    volume = 3'd0;
    send(12'd2047);
    cyc(4);
    check("premute_dac", int'(dac), 15);
    mute = 1'b1;
    cyc(1);
    check("mute_active", int'(active), 0);
    check("mute_lvl_held", int'(dut.lvl_q), 4095);
    n = 0;
    while (dut.lvl_q != 12'd2048 && n < 40000) begin
      cyc(1);
      n++;
    end
    check("mute_slew_time_ok", int'(n > 2046 * 16 && n <= 2047 * 16), 1);
    cyc(40);
    check("mute_hold_lvl", int'(dut.lvl_q), 2048);
    mute = 1'b0;
    cyc(1);
    check("unmute_active", int'(active), 1);
    cyc(2);
    check("unmute_dac", int'(dac), 15);

    cyc(5);
    #2 reset = 1'b1;
    #1;
    check("async_rst_dac", int'(dac), 0);
    check("async_rst_active", int'(active), 0);
    check("async_rst_lvl", int'(dut.lvl_q), 0);
    cyc(1);
    reset = 1'b0;
    cyc(16);
    check("restart_lvl1", int'(dut.lvl_q), 1);
    check("restart_active", int'(active), 0);
    cyc(16);
    check("restart_lvl2", int'(dut.lvl_q), 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sigmadelta_dac.md
# sigmadelta_dac

Audio output stage that consumes the 12-bit signed PCM stream from the tone generators (e.g. the sprung-mass sine oscillator) and drives the board's 4-bit resistor-ladder audio DAC pins. It holds the latest sample, applies a shift-based volume, and converts it to offset-binary. A first-order error-feedback sigma-delta quantizer then produces a 4-bit code every clock. A soft-start/mute state machine slews the output level so power-up and mute produce no click.

## Interface
- C_pcm_bits, 12: input PCM width, signed.
- C_dac_bits, 4: DAC code width.
- C_ramp_shift, 4: the slew step occurs once every 2^C_ramp_shift clocks.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- pcm  in  C_pcm_bits  signed PCM sample.
- pcm_valid  in  1  capture `pcm` on this clock edge.
- volume  in  3  attenuation: arithmetic right shift by `volume`; 0 = full scale.
- mute  in  1  slew the output to midscale and hold it there.
- dac  out  C_dac_bits  quantized DAC code, registered.
- active  out  1  high only in state RUN, registered.

## Operation
- R_sample (signed, reset 0) loads `pcm` when pcm_valid=1 and holds otherwise (zero-order hold). There is no backpressure; every clock is a legal capture.
- S_att = R_sample >>> volume, sign-preserving.
- S_u = S_att + 2^(C_pcm_bits-1), computed as MSB inversion. The result is unsigned 0..4095, with midscale M = 2048.
- R_lvl is unsigned C_pcm_bits wide and resets to 0.
- Ramp tick: a free-running counter of C_ramp_shift bits, reset 0. A tick occurs when the counter is all ones.
- State machine, reset state RAMP:
  - RAMP: on each tick, R_lvl += 1. The transition happens on the tick where R_lvl reaches M: to MUTE if mute=1, otherwise to RUN.
  - RUN: R_lvl <= S_u every clock. If mute=1, go to MUTE on the next edge; R_lvl is not updated from S_u on that edge.
  - MUTE: on each tick, R_lvl moves 1 step toward M, or holds if already at M. If mute=0, go to RUN on the next edge.
- Quantizer, running every clock:
  - R_err is unsigned, C_pcm_bits-C_dac_bits = 8 bits wide, reset 0.
  - sum = R_lvl + R_err, C_pcm_bits+1 = 13 bits wide.
  - dac <= sum[12] ? all ones : sum[11:8].
  - R_err <= sum[7:0].
  - Mean of dac*256 equals R_lvl for R_lvl ≤ 3840. Above 3840 the output is allowed to saturate at 15.
- Reset asserted mid-operation: all registers return to reset values immediately, and the RAMP sequence restarts after release.

## Timing
- Reset values: dac=0, active=0, R_lvl=0, R_err=0, R_sample=0, state RAMP.
- Latency is defined for the sample captured at edge E (pcm_valid=1, state RUN):
  - R_lvl reflects the sample at edge E+1.
  - dac reflects it at edge E+2.
- Volume changes take effect with the same 2-edge latency.
- active:
  - Rises on the same edge that enters RUN.
  - Falls on the same edge that leaves RUN.
- Soft-start duration after reset release: M·2^C_ramp_shift clocks ±2^C_ramp_shift, i.e. 32768 clocks at defaults.
- Simultaneous pcm_valid and mute in RUN: the sample is captured, but the state goes to MUTE and R_lvl is not loaded from it.

## Test plan
- Release reset with mute=0 and pcm=0:
  - dac=0 and active=0 during the first clocks.
  - R_lvl climbs 1 per 16 clocks.
  - active=1 after about 32768 clocks.
  - dac then holds at 8 constantly, with R_err=0.
- RUN, volume=0, pcm=12'sd64 with a single pcm_valid pulse:
  - dac settles to the repeating pattern 8,8,8,9.
  - First change occurs 2 edges after capture.
- RUN with pcm=2047: dac=15 steady.
- RUN with pcm=-2048: dac=0 steady.
- RUN, volume=2, pcm=-1024: R_lvl=1792 and dac=7 steady.
- RUN with pcm=2047, then assert mute:
  - active falls on the next edge.
  - R_lvl decrements 1 per 16 clocks down to 2048, then holds.
  - Deassert mute: active=1 on the next edge and dac=15 two edges later.
- Assert reset mid-RUN:
  - dac=0 and active=0 immediately, asynchronously.
  - After release, RAMP restarts from R_lvl=0.
